// File: rtl/ex_mem_stage_pkg.sv
// Shared constants for the EX->MEM pipeline register.
// Reset/write encodings, zero values, default widths and stall indices.
package ex_mem_stage_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_REG_AW  = 5;
  localparam int DEF_ALUOP_W = 8;
  localparam int DEF_CNT_W   = 2;
  localparam int DEF_STALL_W = 6;

  localparam int EX_IDX  = 3;
  localparam int MEM_IDX = 4;

endpackage

// File: rtl/ex_mem_stage_pipe_field_reg.sv
// Generic pipeline field register: reset/flush > hold > bubble > advance.
// Ports: clk, rst, flush, bubble, hold, d[W] in; q[W] out.
module pipe_field_reg
  import ex_mem_stage_pkg::*;
#(
  parameter int W                = DEF_DATA_W,
  parameter bit CLEAR_ON_BUBBLE  = 1'b1,
  parameter bit CLEAR_ON_ADVANCE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         bubble,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst == RstEnable || flush) begin
      q <= '0;
    end else if (hold) begin
      q <= q;
    end else if (bubble) begin
      q <= CLEAR_ON_BUBBLE ? '0 : d;
    end else begin
      q <= CLEAR_ON_ADVANCE ? '0 : d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with stall/bubble, flush and multi-cycle hold.
// Ports: clk, rst, stall, flush, ex_* in; mem_*, mem_valid, hilo_o, cnt_o out.
module ex_mem_stage #(
  parameter int DATA_W  = ex_mem_stage_pkg::DEF_DATA_W,
  parameter int REG_AW  = ex_mem_stage_pkg::DEF_REG_AW,
  parameter int ALUOP_W = ex_mem_stage_pkg::DEF_ALUOP_W,
  parameter int CNT_W   = ex_mem_stage_pkg::DEF_CNT_W,
  parameter int STALL_W = ex_mem_stage_pkg::DEF_STALL_W,
  parameter int EX_IDX  = ex_mem_stage_pkg::EX_IDX,
  parameter int MEM_IDX = ex_mem_stage_pkg::MEM_IDX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [REG_AW-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [ALUOP_W-1:0]  ex_aluop,
  input  logic [DATA_W-1:0]   ex_mem_addr,
  input  logic [DATA_W-1:0]   ex_reg2,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [CNT_W-1:0]    cnt_i,
  output logic [REG_AW-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic [ALUOP_W-1:0]  mem_aluop,
  output logic [DATA_W-1:0]   mem_mem_addr,
  output logic [DATA_W-1:0]   mem_reg2,
  output logic                mem_valid,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [CNT_W-1:0]    cnt_o
);

  localparam int WB_W = REG_AW + 1 + DATA_W + 1;
  localparam int HL_W = 1 + 2 * DATA_W;
  localparam int MA_W = ALUOP_W + 2 * DATA_W;
  localparam int MC_W = 2 * DATA_W + CNT_W;

  logic bubble;
  logic hold;
  logic unused_stall;

  // A MEM stall freezes the whole register; illegal MEM-only stall
  // therefore also holds.
  assign hold         = stall[MEM_IDX];
  assign bubble       = stall[EX_IDX] & ~stall[MEM_IDX];
  assign unused_stall = ^stall;

  // mem_valid rides in the writeback group as a constant-1 field.
  pipe_field_reg #(
    .W                (WB_W),
    .CLEAR_ON_BUBBLE  (1'b1),
    .CLEAR_ON_ADVANCE (1'b0)
  ) u_wb (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .bubble (bubble),
    .hold   (hold),
    .d      ({ex_wd, ex_wreg, ex_wdata, 1'b1}),
    .q      ({mem_wd, mem_wreg, mem_wdata, mem_valid})
  );

  pipe_field_reg #(
    .W                (HL_W),
    .CLEAR_ON_BUBBLE  (1'b1),
    .CLEAR_ON_ADVANCE (1'b0)
  ) u_hilo (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .bubble (bubble),
    .hold   (hold),
    .d      ({ex_whilo, ex_hi, ex_lo}),
    .q      ({mem_whilo, mem_hi, mem_lo})
  );

  pipe_field_reg #(
    .W                (MA_W),
    .CLEAR_ON_BUBBLE  (1'b1),
    .CLEAR_ON_ADVANCE (1'b0)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .bubble (bubble),
    .hold   (hold),
    .d      ({ex_aluop, ex_mem_addr, ex_reg2}),
    .q      ({mem_aluop, mem_mem_addr, mem_reg2})
  );

  // Partial multi-cycle state: kept across EX's own stall, dropped once
  // the instruction leaves EX.
  pipe_field_reg #(
    .W                (MC_W),
    .CLEAR_ON_BUBBLE  (1'b0),
    .CLEAR_ON_ADVANCE (1'b1)
  ) u_mc (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .bubble (bubble),
    .hold   (hold),
    .d      ({hilo_i, cnt_i}),
    .q      ({hilo_o, cnt_o})
  );

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised EX→MEM pipeline register for the MIPS core, replacing the plain pass-through stage. It adds four things: stall/bubble control from the central stall vector, a flush for exception handling, HI/LO write forwarding, and a hold register for the intermediate state of multi-cycle EX operations (madd/msub/div). It sits between the execute unit and the memory-access unit and feeds the `ctrl` stall logic.

## Interface
Parameters:
- `DATA_W`, 32, width of data, HI, LO, and memory-address fields
- `REG_AW`, 5, register-file address width
- `ALUOP_W`, 8, ALU opcode width carried to MEM
- `CNT_W`, 2, multi-cycle step-counter width
- `STALL_W`, 6, stall vector width
- `EX_IDX`, 3, stall-vector bit index for EX
- `MEM_IDX`, 4, stall-vector bit index for MEM

Ports (name, direction, width, meaning):
- `clk`, in, 1, single clock, rising edge
- `rst`, in, 1, synchronous, active-high reset
- `stall`, in, STALL_W, per-stage stall request from `ctrl`
- `flush`, in, 1, exception flush
- `ex_wd`, in, REG_AW, destination register
- `ex_wreg`, in, 1, register write enable
- `ex_wdata`, in, DATA_W, write data
- `ex_whilo`, in, 1, HI/LO write enable
- `ex_hi`, in, DATA_W, HI value
- `ex_lo`, in, DATA_W, LO value
- `ex_aluop`, in, ALUOP_W, opcode for MEM load/store decode
- `ex_mem_addr`, in, DATA_W, effective address
- `ex_reg2`, in, DATA_W, store data
- `hilo_i`, in, 2·DATA_W, intermediate multi-cycle result from EX
- `cnt_i`, in, CNT_W, step count from EX
- `mem_wd`, `mem_wreg`, `mem_wdata`, `mem_whilo`, `mem_hi`, `mem_lo`, `mem_aluop`, `mem_mem_addr`, `mem_reg2`, out, matching widths, registered copies of the EX fields
- `mem_valid`, out, 1, MEM holds a real instruction (0 = bubble)
- `hilo_o`, out, 2·DATA_W, held intermediate value returned to EX
- `cnt_o`, out, CNT_W, held step count returned to EX

## Operation
Priority on each rising `clk`, highest first:
1. **Reset** (`rst` = 1): every output goes to 0. This includes `mem_valid`, `hilo_o` and `cnt_o`.
2. **Flush** (`flush` = 1): same as reset. Flush overrides any stall.
3. **Bubble** (`stall[EX_IDX]` = 1 and `stall[MEM_IDX]` = 0):
   - All `mem_*` fields become 0 and `mem_valid` = 0.
   - `hilo_o` ← `hilo_i`, `cnt_o` ← `cnt_i`, so EX's partial result survives its own stall.
4. **Hold** (`stall[MEM_IDX]` = 1): all outputs keep their value. EX is necessarily stalled too; `hilo_o` and `cnt_o` are held.
5. **Advance** (no EX/MEM stall):
   - All `mem_*` fields ← `ex_*`, and `mem_valid` = 1.
   - `hilo_o` = 0 and `cnt_o` = 0, because the multi-cycle op has completed.

Other rules:
- Stall bits other than EX_IDX and MEM_IDX are ignored.
- `stall[MEM_IDX]` = 1 with `stall[EX_IDX]` = 0 is illegal. Treat it as Hold; the assertion in the bench flags it.
- No arithmetic is performed; all fields are copied bit-exact.

## Timing
- Latency is 1 cycle from the EX inputs to the `mem_*` outputs. No combinational path from inputs to outputs.
- `hilo_o`/`cnt_o` become visible to EX the cycle after the bubble edge. EX consumes them in its next stalled cycle.
- A `flush` arriving during a multi-cycle op clears `cnt_o`, so EX restarts at step 0.
- `rst` asserted mid-stall clears everything on that edge. The first edge after `rst` falls behaves per the current `stall`/`flush` values.
- Back-to-back bubbles keep capturing the latest `hilo_i`/`cnt_i` every cycle.

## Structure
- Shared package: `RstEnable` = 1'b1, `WriteDisable`, `ZeroWord`, `NOPRegAddr`, default widths, and the stall index constants EX_IDX and MEM_IDX.
- One sub-module, `pipe_field_reg`: a generic DATA-wide register with the reset/flush/bubble/hold/advance selects.
  - Instantiated once per field group (writeback, HI/LO, memory, multi-cycle).
  - It is given `clear_on_bubble` and `clear_on_advance` flags so the `hilo_o`/`cnt_o` group can reuse it.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with all EX inputs 0xFFFF_FFFF → every output is 0 and `mem_valid`=0.
- **Advance:** `ex_wd`=5'h1F, `ex_wreg`=1, `ex_wdata`=0x1234_5678, `ex_whilo`=1, `ex_hi`=0xA, `ex_lo`=0xB, no stall → the next cycle shows identical `mem_*` values and `mem_valid`=1.
- **Bubble and multi-cycle:** `stall`=6'b001111, `hilo_i`=64'h1_0000_0002, `cnt_i`=1 → `mem_wreg`=0, `mem_valid`=0, `hilo_o`=64'h1_0000_0002, `cnt_o`=1. Then release the stall → `cnt_o`=0 and `hilo_o`=0.
- **Hold:** with a valid instruction latched, `stall`=6'b011111 for 3 cycles while the EX inputs change → `mem_*` stays unchanged for all 3 cycles.
- **Flush priority:** `flush`=1 together with `stall`=6'b011111 while `cnt_o`=1 → all outputs 0 on the next edge.
- **Reset mid-operation:** `rst` pulsed for 1 cycle during a bubble sequence with `cnt_o`=1 → `cnt_o`=0. The following unstalled input advances normally, with `mem_valid`=1 one cycle later.
